next_pc_unit: RTL and testbench

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit.sv | 132 +++++++++++++
 tb/tb_next_pc_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Next-PC generation: sequential, branch, jump and register-jump redirects.
// Optional delay slot (DELAY_SLOT) and exception/eret support (macro NPC_EXC_EN).
module next_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          DELAY_SLOT = 0,
    parameter logic [31:0] EXC_VEC    = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic [2:0]  cmp_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [25:0] imm,
    input  logic [31:0] ra,
    output logic [31:0] pc,
    output logic [31:0] pc_4,
    output logic [31:0] link,
    output logic        taken,
    output logic        in_slot
`ifdef NPC_EXC_EN
    ,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] epc
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SLOT = 1'b1
    } state_t;

    localparam bit HAS_SLOT = (DELAY_SLOT != 0);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] tgt;
    logic        cond;
    logic        raw_taken;

    assign pc4    = pc_q + 32'd4;
    assign br_tgt = pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};

    // Zero compares are signed: the sign bit decides negativity.
    always_comb begin
        cond = 1'b0;
        case (cmp_op)
            3'd0:    cond = (rs_val == rt_val);
            3'd1:    cond = (rs_val != rt_val);
            3'd2:    cond = rs_val[31] | (rs_val == 32'd0);
            3'd3:    cond = ~rs_val[31] & (rs_val != 32'd0);
            3'd4:    cond = rs_val[31];
            3'd5:    cond = ~rs_val[31];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        raw_taken = 1'b0;
        tgt       = pc4;
        case (npc_op)
            3'd1: begin
                raw_taken = cond;
                tgt       = br_tgt;
            end
            3'd2: begin
                raw_taken = 1'b1;
                tgt       = {pc_q[31:28], imm, 2'b00};
            end
            3'd3: begin
                raw_taken = 1'b1;
                tgt       = ra;
            end
            default: begin
                raw_taken = 1'b0;
                tgt       = pc4;
            end
        endcase
    end

    assign in_slot = HAS_SLOT && (state_q == SLOT);
    assign taken   = raw_taken & ~in_slot;
    assign pc      = pc_q;
    assign pc_4    = pc4;
    assign link    = HAS_SLOT ? (pc_q + 32'd8) : pc4;

`ifdef NPC_EXC_EN
    logic [31:0] epc_q;
    assign epc = epc_q;
`else
    logic unused_exc_vec;
    assign unused_exc_vec = ^EXC_VEC;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= IDLE;
            pend_q  <= 32'd0;
`ifdef NPC_EXC_EN
            epc_q   <= 32'd0;
        end else if (exc_req) begin
            // A fault in the slot restarts at the branch that owns it.
            epc_q   <= in_slot ? (pc_q - 32'd4) : pc_q;
            pc_q    <= EXC_VEC;
            state_q <= IDLE;
        end else if (eret) begin
            if (!stall) begin
                pc_q    <= epc_q;
                state_q <= IDLE;
            end
`endif
        end else if (!stall) begin
            if (in_slot) begin
                pc_q    <= pend_q;
                state_q <= IDLE;
            end else if (taken && HAS_SLOT) begin
                pend_q  <= tgt;
                pc_q    <= pc4;
                state_q <= SLOT;
            end else begin
                pc_q <= taken ? tgt : pc4;
            end
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: one instance without and one with delay slot.
// Exception scenarios run only when NPC_EXC_EN is defined.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  npc_op = 3'd0;
    logic [2:0]  cmp_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [25:0] imm = 26'd0;
    logic [31:0] ra = 32'd0;

    logic [31:0] pc0, pc4_0, link0;
    logic        taken0, slot0;
    logic [31:0] pc1, pc4_1, link1;
    logic        taken1, slot1;

`ifdef NPC_EXC_EN
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc0, epc1;
`endif

    int tests_run = 0;
    int failures = 0;

    always #5 clk = ~clk;

    next_pc_unit #(.DELAY_SLOT(0)) u_ds0 (
        .clk(clk), .reset(reset), .stall(stall),
        .npc_op(npc_op), .cmp_op(cmp_op),
        .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .ra(ra),
        .pc(pc0), .pc_4(pc4_0), .link(link0),
        .taken(taken0), .in_slot(slot0)
`ifdef NPC_EXC_EN
        , .exc_req(exc_req), .eret(eret), .epc(epc0)
`endif
    );

    next_pc_unit #(.DELAY_SLOT(1)) u_ds1 (
        .clk(clk), .reset(reset), .stall(stall),
        .npc_op(npc_op), .cmp_op(cmp_op),
        .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .ra(ra),
        .pc(pc1), .pc_4(pc4_1), .link(link1),
        .taken(taken1), .in_slot(slot1)
`ifdef NPC_EXC_EN
        , .exc_req(exc_req), .eret(eret), .epc(epc1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        npc_op = 3'd0;
`ifdef NPC_EXC_EN
        exc_req = 1'b0;
        eret = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            tests_run++;
            if (pc0 !== exp_pc[i]) begin
                failures++;
                $display("FAIL reset_seq_ds0[%0d] got %h want %h", i, pc0, exp_pc[i]);
            end
            tests_run++;
            if (pc1 !== exp_pc[i]) begin
                failures++;
                $display("FAIL reset_seq_ds1[%0d] got %h want %h", i, pc1, exp_pc[i]);
            end
        end
        tests_run++;
        if (pc4_0 !== 32'h3010 || link0 !== 32'h3010 || link1 !== 32'h3014) begin
            failures++;
            $display("FAIL pc4_link got %h/%h/%h want 3010/3010/3014", pc4_0, link0, link1);
        end
        tests_run++;
        if (slot0 !== 1'b0 || slot1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_slot got %b/%b want 0/0", slot0, slot1);
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (4) step();
        npc_op = 3'd1;
        cmp_op = 3'd0;
        rs_val = 32'd5;
        rt_val = 32'd5;
        imm = 26'h000FFFE;
        #1;
        tests_run++;
        if (taken0 !== 1'b1) begin
            failures++;
            $display("FAIL br_eq_taken got %b want 1", taken0);
        end
        step();
        tests_run++;
        if (pc0 !== 32'h300C) begin
            failures++;
            $display("FAIL br_eq_pc got %h want 0000300c", pc0);
        end
        npc_op = 3'd0;
        step();
        npc_op = 3'd1;
        rt_val = 32'd6;
        #1;
        tests_run++;
        if (taken0 !== 1'b0) begin
            failures++;
            $display("FAIL br_ne_taken got %b want 0", taken0);
        end
        step();
        tests_run++;
        if (pc0 !== 32'h3014) begin
            failures++;
            $display("FAIL br_ne_pc got %h want 00003014", pc0);
        end
        npc_op = 3'd0;
    endtask

    task automatic test_jump_jr();
        do_reset();
        npc_op = 3'd2;
        imm = 26'h0000C10;
        step();
        tests_run++;
        if (pc0 !== 32'h3040) begin
            failures++;
            $display("FAIL jump_pc got %h want 00003040", pc0);
        end
        npc_op = 3'd3;
        ra = 32'h1234_5679;
        step();
        tests_run++;
        if (pc0 !== 32'h1234_5679) begin
            failures++;
            $display("FAIL jr_pc got %h want 12345679", pc0);
        end
        npc_op = 3'd2;
        imm = 26'h3FF_FFFF;
        step();
        tests_run++;
        if (pc0 !== 32'h1FFF_FFFC) begin
            failures++;
            $display("FAIL jump_region got %h want 1ffffffc", pc0);
        end
        npc_op = 3'd3;
        ra = 32'hFFFF_FFFC;
        step();
        npc_op = 3'd0;
        tests_run++;
        if (pc4_0 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc4 got %h want 00000000", pc4_0);
        end
        step();
        tests_run++;
        if (pc0 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc got %h want 00000000", pc0);
        end
    endtask

    task automatic test_signed();
        logic [2:0]  c_op [8];
        logic [31:0] rs_v [8];
        logic [31:0] rt_v [8];
        logic        exp_t [8];
        c_op = '{3'd3, 3'd4, 3'd2, 3'd5, 3'd3, 3'd1, 3'd6, 3'd2};
        rs_v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                 32'd1, 32'd5, 32'd5, 32'h7FFF_FFFF};
        rt_v = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd6, 32'd5, 32'd0};
        exp_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        npc_op = 3'd1;
        for (int i = 0; i < 8; i++) begin
            cmp_op = c_op[i];
            rs_val = rs_v[i];
            rt_val = rt_v[i];
            #1;
            tests_run++;
            if (taken0 !== exp_t[i]) begin
                failures++;
                $display("FAIL cmp[%0d] op %0d got %b want %b", i, c_op[i], taken0, exp_t[i]);
            end
        end
        npc_op = 3'd5;
        cmp_op = 3'd0;
        rs_val = 32'd1;
        rt_val = 32'd1;
        #1;
        tests_run++;
        if (taken0 !== 1'b0) begin
            failures++;
            $display("FAIL npc_op5_taken got %b want 0", taken0);
        end
        npc_op = 3'd0;
    endtask

    task automatic test_delay_slot();
        do_reset();
        npc_op = 3'd2;
        imm = 26'h0000C10;
        #1;
        tests_run++;
        if (taken1 !== 1'b1 || link1 !== 32'h3008) begin
            failures++;
            $display("FAIL ds_issue got taken %b link %h want 1 00003008", taken1, link1);
        end
        step();
        tests_run++;
        if (pc1 !== 32'h3004 || slot1 !== 1'b1 || taken1 !== 1'b0) begin
            failures++;
            $display("FAIL ds_slot got pc %h slot %b taken %b want 3004 1 0", pc1, slot1, taken1);
        end
        step();
        tests_run++;
        if (pc1 !== 32'h3040 || slot1 !== 1'b0) begin
            failures++;
            $display("FAIL ds_target got pc %h slot %b want 3040 0", pc1, slot1);
        end
        npc_op = 3'd0;
    endtask

    task automatic test_stall_and_reset_in_slot();
        do_reset();
        npc_op = 3'd2;
        imm = 26'h0000C10;
        step();
        npc_op = 3'd0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (pc1 !== 32'h3004 || slot1 !== 1'b1) begin
                failures++;
                $display("FAIL stall_slot[%0d] got pc %h slot %b want 3004 1", i, pc1, slot1);
            end
            tests_run++;
            if (pc0 !== 32'h3040) begin
                failures++;
                $display("FAIL stall_ds0[%0d] got %h want 00003040", i, pc0);
            end
        end
        stall = 1'b0;
        step();
        tests_run++;
        if (pc1 !== 32'h3040 || slot1 !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got pc %h slot %b want 3040 0", pc1, slot1);
        end
        do_reset();
        npc_op = 3'd2;
        step();
        npc_op = 3'd0;
        reset = 1'b1;
        stall = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
        tests_run++;
        if (pc1 !== 32'h3000 || slot1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_slot got pc %h slot %b want 3000 0", pc1, slot1);
        end
        step();
        tests_run++;
        if (pc1 !== 32'h3004 || slot1 !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_slot got pc %h slot %b want 3004 0", pc1, slot1);
        end
    endtask

`ifdef NPC_EXC_EN
    task automatic test_exceptions();
        do_reset();
        repeat (8) step();
        stall = 1'b1;
        exc_req = 1'b1;
        eret = 1'b1;
        step();
        exc_req = 1'b0;
        tests_run++;
        if (pc0 !== 32'h4180 || epc0 !== 32'h3020) begin
            failures++;
            $display("FAIL exc_stall got pc %h epc %h want 4180 3020", pc0, epc0);
        end
        step();
        tests_run++;
        if (pc0 !== 32'h4180) begin
            failures++;
            $display("FAIL eret_stall got %h want 00004180", pc0);
        end
        stall = 1'b0;
        step();
        eret = 1'b0;
        tests_run++;
        if (pc0 !== 32'h3020) begin
            failures++;
            $display("FAIL eret_pc got %h want 00003020", pc0);
        end
        do_reset();
        npc_op = 3'd2;
        imm = 26'h0000C10;
        step();
        npc_op = 3'd0;
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        tests_run++;
        if (pc1 !== 32'h4180 || epc1 !== 32'h3000 || slot1 !== 1'b0) begin
            failures++;
            $display("FAIL exc_slot got pc %h epc %h slot %b want 4180 3000 0", pc1, epc1, slot1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_branch();
        test_jump_jr();
        test_signed();
        test_delay_slot();
        test_stall_and_reset_in_slot();
`ifdef NPC_EXC_EN
        test_exceptions();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
